// File: rtl/trail_body_renderer_pkg.sv
// Shared defaults and saturating helpers for the trail body renderer.
// Helpers work on 32-bit values so any COORD_W up to 31 bits can use them.
package trail_body_renderer_pkg;

    localparam int DEPTH_DEF   = 16;
    localparam int COORD_W_DEF = 16;
    localparam int HALF_W_DEF  = 7;
    localparam int START_X_DEF = 336;
    localparam int START_Y_DEF = 240;

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] maxv);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, maxv}) ? maxv : s[31:0];
    endfunction

endpackage

// File: rtl/trail_body_renderer_if.sv
// Game-state / pixel-mux bundle of the trail body renderer.
interface trail_body_renderer_if #(
    parameter int COORD_W = 16,
    parameter int DEPTH   = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               clear;
    logic               press;
    logic [COORD_W-1:0] head_x;
    logic [COORD_W-1:0] head_y;
    logic [COORD_W-1:0] scroll_x;
    logic [COORD_W-1:0] scroll_y;
    logic               pix_valid;
    logic [9:0]         h_cnt;
    logic [9:0]         v_cnt;
    logic               hit_valid;
    logic               hit;
    logic [CNT_W-1:0]   count;
    logic               full;

    modport master (
        output clear, press, head_x, head_y, scroll_x, scroll_y, pix_valid, h_cnt, v_cnt,
        input  hit_valid, hit, count, full
    );

    modport slave (
        input  clear, press, head_x, head_y, scroll_x, scroll_y, pix_valid, h_cnt, v_cnt,
        output hit_valid, hit, count, full
    );

endinterface

// File: rtl/trail_body_renderer_seg_hit.sv
// Combinational box test of one body segment against a world-space pixel.
module trail_body_renderer_seg_hit
    import trail_body_renderer_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int HALF_W  = HALF_W_DEF
) (
    input  logic [COORD_W-1:0] i_ax,
    input  logic [COORD_W-1:0] i_ay,
    input  logic [COORD_W-1:0] i_bx,
    input  logic [COORD_W-1:0] i_by,
    input  logic [COORD_W-1:0] i_wx,
    input  logic [COORD_W-1:0] i_wy,
    input  logic               i_active,
    output logic               o_hit
);
    localparam logic [31:0] MAXV = 32'((64'd1 << COORD_W) - 64'd1);

    logic [COORD_W-1:0] w_minx, w_maxx, w_miny, w_maxy;
    logic [COORD_W-1:0] w_lox, w_hix, w_loy, w_hiy;

    assign w_minx = (i_ax < i_bx) ? i_ax : i_bx;
    assign w_maxx = (i_ax < i_bx) ? i_bx : i_ax;
    assign w_miny = (i_ay < i_by) ? i_ay : i_by;
    assign w_maxy = (i_ay < i_by) ? i_by : i_ay;

    // Clamp at the world edges so a box never wraps onto the far side.
    assign w_lox = COORD_W'(sat_sub(32'(w_minx), 32'(HALF_W)));
    assign w_hix = COORD_W'(sat_add(32'(w_maxx), 32'(HALF_W), MAXV));
    assign w_loy = COORD_W'(sat_sub(32'(w_miny), 32'(HALF_W)));
    assign w_hiy = COORD_W'(sat_add(32'(w_maxy), 32'(HALF_W), MAXV));

    assign o_hit = i_active && (i_wx >= w_lox) && (i_wx <= w_hix)
                            && (i_wy >= w_loy) && (i_wy <= w_hiy);

endmodule

// File: rtl/trail_body_renderer.sv
// Turn-point ring buffer plus a 2-stage per-pixel "on body" test for the pixel mixer.
module trail_body_renderer
    import trail_body_renderer_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int COORD_W = COORD_W_DEF,
    parameter int HALF_W  = HALF_W_DEF,
    parameter int START_X = START_X_DEF,
    parameter int START_Y = START_Y_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    trail_body_renderer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [COORD_W-1:0] w_ent_x [DEPTH];
    logic [COORD_W-1:0] w_ent_y [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_press_q;
    logic [PTR_W-1:0]   w_newest;
    logic               w_dup;
    logic               w_push;

    assign w_newest = r_wr_ptr - PTR_W'(1);
    assign w_dup    = (bus.head_x == w_ent_x[w_newest]) && (bus.head_y == w_ent_y[w_newest]);
    assign w_push   = bus.press & ~r_press_q & ~w_dup;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_press_q <= 1'b0;
            r_wr_ptr  <= PTR_W'(1);
            r_count   <= CNT_W'(1);
        end else if (bus.clear) begin
            r_press_q <= 1'b0;
            r_wr_ptr  <= PTR_W'(1);
            r_count   <= CNT_W'(1);
        end else begin
            r_press_q <= bus.press;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (r_count != CNT_W'(DEPTH))
                    r_count <= r_count + CNT_W'(1);
            end
        end
    end

    // Only slot 0 holds meaningful data after reset; the others are masked by count.
    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        logic [COORD_W-1:0] r_x, r_y;
        if (e == 0) begin : g_start
            always_ff @(posedge i_clk or negedge i_reset) begin
                if (!i_reset || bus.clear) begin
                    r_x <= COORD_W'(START_X);
                    r_y <= COORD_W'(START_Y);
                end else if (w_push && r_wr_ptr == PTR_W'(0)) begin
                    r_x <= bus.head_x;
                    r_y <= bus.head_y;
                end
            end
        end else begin : g_plain
            always_ff @(posedge i_clk) begin
                if (w_push && !bus.clear && r_wr_ptr == PTR_W'(e)) begin
                    r_x <= bus.head_x;
                    r_y <= bus.head_y;
                end
            end
        end
        assign w_ent_x[e] = r_x;
        assign w_ent_y[e] = r_y;
    end

    // Stage 1: screen -> world translation, head snapshot
    logic [COORD_W-1:0] r_wx_p1, r_wy_p1, r_hx_p1, r_hy_p1;
    logic               r_vld_p1;

    always_ff @(posedge i_clk) begin
        r_wx_p1 <= {{(COORD_W-10){1'b0}}, bus.h_cnt} + bus.scroll_x - COORD_W'(1);
        r_wy_p1 <= {{(COORD_W-10){1'b0}}, bus.v_cnt} + bus.scroll_y - COORD_W'(1);
        r_hx_p1 <= bus.head_x;
        r_hy_p1 <= bus.head_y;
    end

    // Stage 2: per-segment box tests, OR-reduced
    logic [DEPTH-1:0] w_seg_hit;

    for (genvar k = 0; k < DEPTH; k++) begin : g_seg
        logic [COORD_W-1:0] w_ax, w_ay, w_bx, w_by;
        logic               w_act;
        if (k == 0) begin : g_head
            assign w_ax  = w_ent_x[w_newest];
            assign w_ay  = w_ent_y[w_newest];
            assign w_bx  = r_hx_p1;
            assign w_by  = r_hy_p1;
            assign w_act = 1'b1;
        end else begin : g_body
            logic [PTR_W-1:0] w_ia, w_ib;
            assign w_ia  = r_wr_ptr - PTR_W'(k);
            assign w_ib  = w_ia - PTR_W'(1);
            assign w_ax  = w_ent_x[w_ia];
            assign w_ay  = w_ent_y[w_ia];
            assign w_bx  = w_ent_x[w_ib];
            assign w_by  = w_ent_y[w_ib];
            assign w_act = (r_count > CNT_W'(k));
        end
        trail_body_renderer_seg_hit #(.COORD_W(COORD_W), .HALF_W(HALF_W)) u_seg (
            .i_ax(w_ax), .i_ay(w_ay), .i_bx(w_bx), .i_by(w_by),
            .i_wx(r_wx_p1), .i_wy(r_wy_p1), .i_active(w_act), .o_hit(w_seg_hit[k])
        );
    end

    logic r_vld_p2, r_hit_p2;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_hit_p2 <= 1'b0;
        end else begin
            r_vld_p1 <= bus.pix_valid;
            r_vld_p2 <= r_vld_p1;
            r_hit_p2 <= r_vld_p1 & (|w_seg_hit);
        end
    end

    assign bus.hit_valid = r_vld_p2;
    assign bus.hit       = r_hit_p2;
    assign bus.count     = r_count;
    assign bus.full      = (r_count == CNT_W'(DEPTH));

endmodule

// File: tb/tb_trail_body_renderer.sv
// Bench for trail_body_renderer: table vectors plus hand-written sequences, scoreboard-checked.
module tb_trail_body_renderer;

    localparam int DEPTH = 16;
    localparam int HALF  = 7;
    localparam int MAXC  = 65535;
    localparam int SX0   = 336;
    localparam int SY0   = 240;

    typedef struct {
        int h;
        int v;
        int sx;
        int sy;
        bit exp_hit;
    } vec_t;

    typedef struct {
        bit exp_hit;
        int id;
    } sb_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    trail_body_renderer_if #(.COORD_W(16), .DEPTH(DEPTH)) bus();

    trail_body_renderer #(.DEPTH(DEPTH), .COORD_W(16), .HALF_W(HALF),
                          .START_X(SX0), .START_Y(SY0)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus.slave)
    );

    int  checks = 0;
    int  failures = 0;
    int  next_id = 0;
    sb_t sb[$];
    int  mx[$];
    int  my[$];
    int  hx = 0;
    int  hy = 0;

    // ---------------- reference model ----------------
    function automatic bit in_box(int ax, int ay, int bx, int by, int wx, int wy);
        int lox, hix, loy, hiy;
        lox = ((ax < bx) ? ax : bx) - HALF;  if (lox < 0) lox = 0;
        hix = ((ax > bx) ? ax : bx) + HALF;  if (hix > MAXC) hix = MAXC;
        loy = ((ay < by) ? ay : by) - HALF;  if (loy < 0) loy = 0;
        hiy = ((ay > by) ? ay : by) + HALF;  if (hiy > MAXC) hiy = MAXC;
        return (wx >= lox) && (wx <= hix) && (wy >= loy) && (wy <= hiy);
    endfunction

    function automatic bit model_hit(int h, int v, int sx, int sy);
        int wx, wy;
        bit r;
        wx = (h + sx - 1) & 32'hFFFF;
        wy = (v + sy - 1) & 32'hFFFF;
        r = in_box(mx[mx.size()-1], my[my.size()-1], hx, hy, wx, wy);
        for (int i = 0; i + 1 < mx.size(); i++)
            if (in_box(mx[i], my[i], mx[i+1], my[i+1], wx, wy)) r = 1'b1;
        return r;
    endfunction

    function automatic void model_clear();
        mx.delete(); my.delete();
        mx.push_back(SX0); my.push_back(SY0);
    endfunction

    function automatic void model_push(int x, int y);
        if (mx[mx.size()-1] == x && my[my.size()-1] == y) return;
        mx.push_back(x); my.push_back(y);
        if (mx.size() > DEPTH) begin
            void'(mx.pop_front());
            void'(my.pop_front());
        end
    endfunction

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        checks++;
        if (bus.hit_valid === 1'b1) begin
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_hit_valid hit=%0b with empty scoreboard t=%0t", bus.hit, $time);
            end else begin
                sb_t e;
                e = sb.pop_front();
                if (bus.hit !== e.exp_hit) begin
                    failures++;
                    $display("FAIL pixel_%0d hit actual=%0b expected=%0b t=%0t", e.id, bus.hit, e.exp_hit, $time);
                end
            end
        end else if (bus.hit !== 1'b0) begin
            failures++;
            $display("FAIL hit_without_valid actual=%0b expected=0 t=%0t", bus.hit, $time);
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic set_head(int x, int y);
        hx = x; hy = y;
        bus.head_x = 16'(x);
        bus.head_y = 16'(y);
    endtask

    task automatic pixel(int h, int v, int sx, int sy, bit use_exp, bit exp_in);
        sb_t e;
        @(posedge clk); #1;
        bus.pix_valid = 1'b1;
        bus.h_cnt    = 10'(h);
        bus.v_cnt    = 10'(v);
        bus.scroll_x = 16'(sx);
        bus.scroll_y = 16'(sy);
        e.exp_hit = use_exp ? exp_in : model_hit(h, v, sx, sy);
        e.id = next_id++;
        sb.push_back(e);
    endtask

    task automatic pixel_world(int x, int y);
        pixel(100, 100, x - 99, y - 99, 1'b0, 1'b0);
    endtask

    task automatic drain();
        @(posedge clk); #1;
        bus.pix_valid = 1'b0;
        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        chk("drain_pending", sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_press(int hold);
        @(posedge clk); #1;
        bus.press = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        bus.press = 1'b0;
        model_push(hx, hy);
    endtask

    task automatic do_clear();
        @(posedge clk); #1;
        bus.clear = 1'b1;
        @(posedge clk); #1;
        bus.clear = 1'b0;
        model_clear();
    endtask

    task automatic check_cnt(string name, int exp_count, int exp_full);
        @(negedge clk);
        chk({name, "_count"}, int'(bus.count), exp_count);
        chk({name, "_full"}, int'(bus.full), exp_full);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        vec_t t1[7];
        vec_t t2[5];
        t1[0] = '{336, 240, 1, 1, 1'b1};
        t1[1] = '{344, 240, 1, 1, 1'b0};
        t1[2] = '{343, 247, 1, 1, 1'b1};
        t1[3] = '{329, 233, 1, 1, 1'b1};
        t1[4] = '{328, 240, 1, 1, 1'b0};
        t1[5] = '{336, 248, 1, 1, 1'b0};
        t1[6] = '{336, 232, 1, 1, 1'b0};
        t2[0] = '{380, 247, 1, 1, 1'b1};
        t2[1] = '{380, 248, 1, 1, 1'b0};
        t2[2] = '{407, 240, 1, 1, 1'b1};
        t2[3] = '{408, 240, 1, 1, 1'b0};
        t2[4] = '{329, 233, 1, 1, 1'b1};

        bus.clear = 1'b0; bus.press = 1'b0; bus.pix_valid = 1'b0;
        bus.h_cnt = '0; bus.v_cnt = '0; bus.scroll_x = 16'd1; bus.scroll_y = 16'd1;
        set_head(SX0, SY0);
        model_clear();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_count", int'(bus.count), 1);
        chk("reset_full", int'(bus.full), 0);
        chk("reset_hit_valid", int'(bus.hit_valid), 0);
        chk("reset_hit", int'(bus.hit), 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Single start point, head on it
        foreach (t1[i]) pixel(t1[i].h, t1[i].v, t1[i].sx, t1[i].sy, 1'b1, t1[i].exp_hit);
        drain();

        // Held press records one point
        set_head(400, 240);
        do_press(5);
        check_cnt("one_push", 2, 0);
        foreach (t2[i]) pixel(t2[i].h, t2[i].v, t2[i].sx, t2[i].sy, 1'b1, t2[i].exp_hit);
        drain();

        // Duplicate suppression
        do_press(1);
        check_cnt("dup_push", 2, 0);

        // Clear beats a simultaneous press edge
        set_head(500, 300);
        @(posedge clk); #1;
        bus.clear = 1'b1; bus.press = 1'b1;
        @(posedge clk); #1;
        bus.clear = 1'b0; bus.press = 1'b0;
        model_clear();
        check_cnt("clear_press", 1, 0);
        pixel(336, 240, 1, 1, 1'b0, 1'b0);
        pixel(510, 300, 1, 1, 1'b0, 1'b0);
        drain();

        // Fill past DEPTH: oldest segments age out
        do_clear();
        for (int i = 1; i <= 20; i++) begin
            set_head(1000 + 100 * i, 1000 + 100 * i);
            do_press(1);
            if (i == 14) check_cnt("fill15", 15, 0);
            if (i == 15) check_cnt("fill16", 16, 1);
        end
        check_cnt("fill20", 16, 1);
        pixel_world(340, 240);
        for (int i = 1; i <= 19; i++) pixel_world(1050 + 100 * i, 1050 + 100 * i);
        drain();
        set_head(3000, 3500);
        pixel_world(3000, 3300);
        pixel_world(3000, 3600);
        drain();

        // Saturated box edge, and wrap of the world coordinate at scroll 0
        do_clear();
        set_head(3, 3);
        do_press(1);
        check_cnt("sat_push", 2, 0);
        set_head(3, 100);
        pixel(0, 50, 1, 1, 1'b1, 1'b1);
        pixel(0, 50, 0, 1, 1'b1, 1'b0);
        pixel(5, 50, 0, 1, 1'b1, 1'b1);
        drain();

        // Reset asserted and released while pixels stream
        set_head(SX0, SY0);
        repeat (3) pixel(336, 240, 1, 1, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        model_clear();
        @(negedge clk);
        chk("midrst_hit_valid", int'(bus.hit_valid), 0);
        chk("midrst_count", int'(bus.count), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        begin
            sb_t e;
            e.exp_hit = 1'b1;
            e.id = next_id++;
            sb.push_back(e);
        end
        @(negedge clk);
        chk("rst_gap1_hit_valid", int'(bus.hit_valid), 0);
        pixel(336, 240, 1, 1, 1'b1, 1'b1);
        @(negedge clk);
        chk("rst_gap2_hit_valid", int'(bus.hit_valid), 0);
        pixel(344, 240, 1, 1, 1'b1, 1'b0);
        pixel(336, 240, 1, 1, 1'b1, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
